// File: rtl/conv3x3_engine.sv
// Streaming 3x3 correlation stage: builds a sliding window from 3-pixel columns,
// applies a double-buffered signed kernel, then shifts and saturates the sum.
module conv3x3_engine #(
  parameter int RAM_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int COEF_WIDTH   = 8,
  parameter int SHIFT        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  input  logic [RAM_WIDTH-1:0]         i_to_conv0,
  input  logic [RAM_WIDTH-1:0]         i_to_conv1,
  input  logic [RAM_WIDTH-1:0]         i_to_conv2,
  input  logic                         i_coef_valid,
  input  logic signed [COEF_WIDTH-1:0] i_coef,
  output logic [RAM_WIDTH-1:0]         o_pixel,
  output logic                         o_valid,
  output logic                         o_frame_done
);

  localparam int PW = RAM_WIDTH + COEF_WIDTH + 1;
  localparam int SW = PW + 4;
  localparam int CW = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 2;
  localparam int RC = (IMAGE_HEIGHT > 3) ? $clog2(IMAGE_HEIGHT - 2) : 1;
  localparam logic signed [COEF_WIDTH-1:0] CENTER  = COEF_WIDTH'(1 << SHIFT);
  localparam logic signed [SW-1:0]         PIX_MAX = SW'((1 << RAM_WIDTH) - 1);

  logic [CW-1:0]                col_q;
  logic [RC-1:0]                row_q;
  logic [3:0]                   idx_q;
  logic [RAM_WIDTH-1:0]         win_q    [3][2];
  logic signed [COEF_WIDTH-1:0] shadow_q [9];
  logic signed [COEF_WIDTH-1:0] kern_q   [9];
  logic signed [PW-1:0]         prod_q   [9];
  logic signed [SW-1:0]         sum_q;
  logic                         v1_q, fd1_q, v2_q, fd2_q;

  logic [RAM_WIDTH-1:0]         pix_in   [3];
  logic [RAM_WIDTH-1:0]         tap      [9];
  logic signed [PW-1:0]         prod_d   [9];
  logic signed [SW-1:0]         sum_d;
  logic signed [SW-1:0]         shifted_d;
  logic [RAM_WIDTH-1:0]         pix_d;
  logic                         last_col, last_row, win_valid, frame_start;

  assign pix_in[0] = i_to_conv0;
  assign pix_in[1] = i_to_conv1;
  assign pix_in[2] = i_to_conv2;

  assign last_col    = (col_q == CW'(IMAGE_WIDTH - 1));
  assign last_row    = (row_q == RC'(IMAGE_HEIGHT - 3));
  assign win_valid   = i_valid && (col_q >= CW'(2));
  assign frame_start = i_valid && (col_q == '0) && (row_q == '0);

  // The live input column serves as the newest window column, so only two are stored.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign tap[gi*3 + 0] = win_q[gi][0];
      assign tap[gi*3 + 1] = win_q[gi][1];
      assign tap[gi*3 + 2] = pix_in[gi];
    end
    for (gi = 0; gi < 9; gi++) begin : g_mul
      assign prod_d[gi] = PW'($signed({1'b0, tap[gi]})) * PW'(kern_q[gi]);
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + SW'(prod_q[k]);
    end
  end

  always_comb begin
    shifted_d = sum_q >>> SHIFT;
    pix_d     = shifted_d[RAM_WIDTH-1:0];
    if (shifted_d < 0) begin
      pix_d = '0;
    end else if (shifted_d > PIX_MAX) begin
      pix_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      v1_q         <= 1'b0;
      fd1_q        <= 1'b0;
      v2_q         <= 1'b0;
      fd2_q        <= 1'b0;
      sum_q        <= '0;
      o_pixel      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= (k == 4) ? CENTER : '0;
        kern_q[k]   <= (k == 4) ? CENTER : '0;
        prod_q[k]   <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      if (i_valid) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + RC'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= pix_in[r];
        end
      end
      // Active kernel takes the shadow as it was before any same-cycle write.
      if (frame_start) begin
        for (int k = 0; k < 9; k++) begin
          kern_q[k] <= shadow_q[k];
        end
      end
      if (i_coef_valid) begin
        shadow_q[idx_q] <= i_coef;
        idx_q           <= (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
      end
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= prod_d[k];
      end
      v1_q         <= win_valid;
      fd1_q        <= win_valid && last_col && last_row;
      sum_q        <= sum_d;
      v2_q         <= v1_q;
      fd2_q        <= fd1_q;
      o_pixel      <= pix_d;
      o_valid      <= v2_q;
      o_frame_done <= fd2_q;
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Randomized bench for conv3x3_engine: a frame-level correlation model predicts
// every output pixel, its frame-done flag and the cycle it must appear in.
module tb_conv3x3_engine;

  localparam int RW = 8;
  localparam int W  = 10;
  localparam int H  = 10;
  localparam int SH = 4;
  localparam int NOUT = (W - 2) * (H - 2);

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [RW-1:0]     i_to_conv0, i_to_conv1, i_to_conv2;
  logic              i_coef_valid;
  logic signed [7:0] i_coef;
  logic [RW-1:0]     o_pixel;
  logic              o_valid;
  logic              o_frame_done;

  conv3x3_engine #(
    .RAM_WIDTH(RW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COEF_WIDTH(8), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid),
    .i_to_conv0(i_to_conv0), .i_to_conv1(i_to_conv1), .i_to_conv2(i_to_conv2),
    .i_coef_valid(i_coef_valid), .i_coef(i_coef),
    .o_pixel(o_pixel), .o_valid(o_valid), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pix;
    int fd;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   coef_q[$];
  int   img[H][W];
  int   kshadow[9];
  int   kactive[9];
  int   midx;
  int   out_cnt;
  bit   stopped;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_pixel(input int t, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img[t + i][c - 2 + j] * kactive[i*3 + j];
    s = s >>> SH;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      kshadow[k] = (k == 4) ? (1 << SH) : 0;
      kactive[k] = kshadow[k];
    end
    midx = 0;
  endtask

  // Output monitor: samples 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, o_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", {24'd0, o_pixel}, mon_e.pix);
        check("frame_done", {31'd0, o_frame_done}, mon_e.fd);
        check("latency", cyc, mon_e.cyc);
        out_cnt++;
      end
    end else begin
      if (o_frame_done) check("fd_without_valid", 32'd1, 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_valid", {31'd0, o_valid}, 32'd1);
      end
    end
  end

  task automatic fill_img(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (pat == 0) ? 10*r + c : (pat == 1) ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic push_coef(input int v);
    logic [31:0] vb;
    vb = v;
    i_coef_valid = 1'b1;
    i_coef = vb[7:0];
    kshadow[midx] = v;
    midx = (midx + 1) % 9;
  endtask

  task automatic load_coefs();
    while (coef_q.size() > 0) begin
      @(negedge clk);
      i_valid = 1'b0;
      push_coef(coef_q.pop_front());
    end
    @(negedge clk);
    i_coef_valid = 1'b0;
  endtask

  task automatic do_reset_mid();
    exp_q.delete();
    reset = 1'b1;
    i_valid = 1'b0;
    i_coef_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_mid_pixel", {24'd0, o_pixel}, 32'd0);
    check("rst_mid_fd", {31'd0, o_frame_done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("rst_mid_valid", {31'd0, o_valid}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic stream_frame(input int pat, input int gap_max, input int coef_start,
                              input int stop_after);
    int col_idx = 0;
    int gaps;
    fill_img(pat);
    for (int k = 0; k < 9; k++) kactive[k] = kshadow[k];
    out_cnt = 0;
    stopped = 1'b0;
    for (int t = 0; t < H - 2; t++) begin
      for (int c = 0; c < W; c++) begin
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gaps) begin
          @(negedge clk);
          i_valid = 1'b0;
          i_coef_valid = 1'b0;
        end
        @(negedge clk);
        if (stop_after >= 0 && out_cnt >= stop_after) begin
          stopped = 1'b1;
          do_reset_mid();
          return;
        end
        i_valid = 1'b1;
        i_to_conv0 = img[t][c][RW-1:0];
        i_to_conv1 = img[t+1][c][RW-1:0];
        i_to_conv2 = img[t+2][c][RW-1:0];
        if (col_idx >= coef_start && coef_q.size() > 0) push_coef(coef_q.pop_front());
        else i_coef_valid = 1'b0;
        if (c >= 2)
          exp_q.push_back('{pix: ref_pixel(t, c), fd: (t == H-3 && c == W-1) ? 1 : 0,
                            cyc: cyc + 3});
        col_idx++;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_coef_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
    check("out_count", out_cnt, NOUT);
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0;
    i_coef_valid = 1'b0;
    i_coef = '0;
    i_to_conv0 = '0;
    i_to_conv1 = '0;
    i_to_conv2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pixel", {24'd0, o_pixel}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_fd", {31'd0, o_frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Identity kernel on the ramp frame
    stream_frame(0, 0, 1 << 30, -1);

    // Box kernel loaded mid-frame: this frame stays identity, the next one is box
    repeat (9) coef_q.push_back(1);
    stream_frame(0, 0, 20, -1);
    stream_frame(0, 0, 1 << 30, -1);

    // Saturation high and low
    repeat (9) coef_q.push_back(127);
    load_coefs();
    stream_frame(1, 0, 1 << 30, -1);
    for (int k = 0; k < 9; k++) coef_q.push_back((k == 4) ? -16 : 0);
    load_coefs();
    stream_frame(1, 0, 1 << 30, -1);

    // Identity again with random idle gaps between columns
    for (int k = 0; k < 9; k++) coef_q.push_back((k == 4) ? 16 : 0);
    load_coefs();
    stream_frame(0, 5, 1 << 30, -1);

    // Ten random coefficients from the first column (same-cycle frame start, wrap to k00)
    repeat (10) coef_q.push_back(int'($urandom_range(0, 255)) - 128);
    stream_frame(2, 2, 0, -1);
    stream_frame(2, 0, 1 << 30, -1);
    stream_frame(2, 3, 1 << 30, -1);

    // Reset after 20 outputs, then a clean identity frame
    stream_frame(0, 0, 1 << 30, 20);
    check("reset_taken", {31'd0, stopped}, 32'd1);
    stream_frame(0, 0, 1 << 30, -1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

- Streaming 3x3 convolution stage directly downstream of `bram_control` (TO_PROCESS=1).
- Consumes one 3-pixel column per valid cycle (`o_to_conv0..2` / `o_valid_data_to_conv`) and builds a sliding 3x3 window.
- Applies a programmable signed kernel and emits one normalized, saturated pixel per valid window.
- Output feeds the processed-frame `bram_control` (TO_PROCESS=0) load port.

## Interface

Parameters:

- RAM_WIDTH, 8, pixel width (unsigned).
- IMAGE_WIDTH, 10, columns per row triplet.
- IMAGE_HEIGHT, 10, frame rows; the frame carries IMAGE_HEIGHT-2 row triplets.
- COEF_WIDTH, 8, signed coefficient width.
- SHIFT, 4, arithmetic right shift applied to the accumulated sum.

Ports:

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  column valid (from `o_valid_data_to_conv`).
- i_to_conv0  in  RAM_WIDTH  top-row pixel.
- i_to_conv1  in  RAM_WIDTH  middle-row pixel.
- i_to_conv2  in  RAM_WIDTH  bottom-row pixel.
- i_coef_valid  in  1  coefficient write strobe.
- i_coef  in  COEF_WIDTH  signed coefficient, raster order k00,k01,…,k22.
- o_pixel  out  RAM_WIDTH  convolved pixel.
- o_valid  out  1  o_pixel valid, one-cycle pulse per pixel.
- o_frame_done  out  1  pulse coincident with the last o_valid of a frame.

## Operation

- **Window.** Three 3-deep column shift registers advance only on i_valid. Column c is the newest; window column 0 is the oldest (c-2). Row 0 is i_to_conv0.
- **Kernel orientation.** k[r][j] multiplies window[r][j] (correlation, no flip).
- **Counters.**
  - col_cnt runs 0..IMAGE_WIDTH-1 and advances on i_valid. It wraps to 0 after IMAGE_WIDTH-1 and increments row_cnt.
  - row_cnt runs 0..IMAGE_HEIGHT-3 and wraps to 0 after the last column of the last triplet (end of frame).
- **Window valid.** A window is valid on an i_valid cycle with col_cnt ≥ 2. This gives IMAGE_WIDTH-2 outputs per triplet and (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) per frame. Windows never span a row-triplet boundary, because the column registers are logically restarted at col_cnt=0.
- **Kernel loading.**
  - Each i_coef_valid writes i_coef into shadow[idx]; idx cycles 0..8 and wraps to 0.
  - The shadow copies into the active kernel on the i_valid cycle with col_cnt=0 and row_cnt=0 (frame start).
  - A load mid-frame therefore never alters the current frame.
- **Arithmetic.**
  - Pixels are zero-extended to signed RAM_WIDTH+1 bits.
  - Products are RAM_WIDTH+COEF_WIDTH+1 bits.
  - The sum of 9 products is widened by 4 bits, so there is no internal overflow.
  - The sum is arithmetically shifted right by SHIFT, which floors toward −∞.
  - The result saturates to [0, 2^RAM_WIDTH−1].
- **No backpressure.** i_valid gaps of any length are allowed and the pipeline drains independently of i_valid.

## Timing

- **Pipeline stages.**
  - T = the cycle in which i_valid completes a window.
  - T+1: 9 products registered.
  - T+2: sum registered.
  - T+3: shift/saturate registered, o_valid=1.
  - Latency is exactly 3 cycles.
- **Throughput.** One output per cycle when i_valid is held high.
- **Frame end.** The end-of-frame flag travels with the last window; o_frame_done=1 in the same cycle as that o_valid and is 0 otherwise.
- **Coefficient write.** i_coef_valid and i_valid in the same cycle at frame start: the coefficient is written to the shadow only. The active kernel takes the pre-write shadow.
- **Reset values (cycle after reset is sampled high).**
  - o_pixel=0, o_valid=0, o_frame_done=0.
  - col_cnt=0, row_cnt=0, coef idx=0.
  - Pipeline valid bits cleared.
  - Shadow and active kernel set to identity: center = 1<<SHIFT, others 0.
- **Reset mid-frame.** In-flight pixels are discarded with no further o_valid. The next i_valid is treated as column 0 of triplet 0.

## Test plan

1. **Identity kernel.** After reset, stream a 10x10 frame with p(r,c)=10r+c.
   - Required: 64 outputs, in order 11..18, 21..28, …, 81..88.
   - o_frame_done with the output 88.
   - Each o_valid exactly 3 cycles after its completing column.
2. **Box kernel.** Load all ones (SHIFT=4), then stream two frames.
   - Frame 1 is still identity.
   - Frame 2 first output is floor(99/16)=6 and last is floor(792/16)=49.
3. **Saturation.**
   - Constant 255 frame with all coefficients 127: every output is 255.
   - Center coefficient −16, others 0: every output is 0.
4. **Input gaps.** Insert 0–5 random idle cycles between columns.
   - Identical value sequence to scenario 1.
   - o_valid never asserted except 3 cycles after a completing column.
5. **Coefficient load mid-frame.** Load 9 coefficients mid-frame.
   - Current frame is unchanged.
   - The new kernel applies from the next frame.
   - A 10th write wraps to k00.
6. **Reset mid-frame.** Assert reset after 20 outputs.
   - o_valid=0 from the next cycle with no pending outputs.
   - A fresh frame reproduces scenario 1 exactly, with the identity kernel.
